uart_rx_word: RTL and testbench

- Receive side of the board's 9600-baud serial link.
- Consumes the line produced by the two-byte transmitter: 8N1 framing, LSB first, two bytes per word, no idle gap between the bytes.
- Oversamples the line, reassembles each 16-bit word and presents it with a one-cycle valid pulse to the downstream command/display logic.
- Flags framing errors and an incomplete word (missing second byte).

---
 rtl/uart_rx_word.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_word.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_word
//  Description : 8N1 serial receiver that pairs consecutive bytes into 16-bit
//                words (first byte low). Oversampled, mid-bit sampling,
//                framing-error and missing-second-byte timeout detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_word #(
    parameter int OVERSAMPLE   = 16,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk_153k6hz,
    input  logic        reset,
    input  logic        rx,
    output logic [15:0] data,
    output logic        valid,
    output logic        err,
    output logic        busy
);

    localparam int C_CNT_W    = $clog2(OVERSAMPLE);
    localparam int C_TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
    localparam int C_TO_W     = $clog2(C_TO_LIMIT + 1);

    localparam logic [C_CNT_W-1:0] c_half_m1 = C_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [C_CNT_W-1:0] c_last    = C_CNT_W'(OVERSAMPLE - 1);
    localparam logic [C_TO_W-1:0]  c_to_last = C_TO_W'(C_TO_LIMIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic                rx_meta_q,   rx_meta_d;
    logic                rx_s_q,      rx_s_d;
    logic [C_CNT_W-1:0]  cnt_q,       cnt_d;
    logic [2:0]          bit_q,       bit_d;
    logic [7:0]          shift_q,     shift_d;
    logic [7:0]          low_q,       low_d;
    logic                byte_idx_q,  byte_idx_d;
    logic [C_TO_W-1:0]   timer_q,     timer_d;
    logic                wait_high_q, wait_high_d;
    logic [15:0]         data_q,      data_d;
    logic                valid_q,     valid_d;
    logic                err_q,       err_d;

    // Next-state logic for the synchronizer, receive FSM, word assembly and timeout
    always_comb begin
        state_d     = state_q;
        rx_meta_d   = rx;
        rx_s_d      = rx_meta_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        low_d       = low_q;
        byte_idx_d  = byte_idx_q;
        timer_d     = timer_q;
        wait_high_d = wait_high_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Holding byte 1: give up on the word once the gap is too long
                if (byte_idx_q) begin
                    if (timer_q == c_to_last) begin
                        byte_idx_d = 1'b0;
                        timer_d    = '0;
                        err_d      = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end else begin
                    timer_d = '0;
                end

                // After a framing error the line must go high before a new
                // start edge is accepted, so a stuck-low line is one error only
                if (wait_high_q) begin
                    if (rx_s_q) begin
                        wait_high_d = 1'b0;
                    end
                end else if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    timer_d = '0;
                end
            end

            S_START: begin
                if (cnt_q == c_half_m1) begin
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        bit_d   = 3'd0;
                    end else begin
                        // Start bit did not hold to mid-bit: treat as noise
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (cnt_q == c_last) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = '0;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_STOP: begin
                if (cnt_q == c_last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (rx_s_q) begin
                        if (!byte_idx_q) begin
                            low_d      = shift_q;
                            byte_idx_d = 1'b1;
                        end else begin
                            data_d     = {shift_q, low_q};
                            valid_d    = 1'b1;
                            byte_idx_d = 1'b0;
                        end
                    end else begin
                        err_d       = 1'b1;
                        byte_idx_d  = 1'b0;
                        wait_high_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_153k6hz) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            low_q       <= 8'h00;
            byte_idx_q  <= 1'b0;
            timer_q     <= '0;
            wait_high_q <= 1'b0;
            data_q      <= 16'h0000;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            low_q       <= low_d;
            byte_idx_q  <= byte_idx_d;
            timer_q     <= timer_d;
            wait_high_q <= wait_high_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign busy  = (state_q != S_IDLE) | byte_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_word
//  Description : Self-checking bench for uart_rx_word. Words are pushed to an
//                expected queue as they are transmitted and popped when the
//                receiver pulses valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_word;

    localparam int OS      = 16;
    localparam int TO_BITS = 20;
    // Edges from driving a start bit to the edge that registers its stop sample:
    // 2 synchronizer + 1 idle detect + half bit + 8 data bits + stop bit
    localparam int STOP_LAT = 3 + OS / 2 + 9 * OS;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        rx    = 1'b1;
    logic [15:0] data;
    logic        valid;
    logic        err;
    logic        busy;

    int total     = 0;
    int bad       = 0;
    int cyc       = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int err_cyc   = -1;

    logic [15:0] exp_q[$];
    logic [15:0] exp_w;

    uart_rx_word #(
        .OVERSAMPLE   (OS),
        .TIMEOUT_BITS (TO_BITS)
    ) dut (
        .clk_153k6hz (clk),
        .reset       (reset),
        .rx          (rx),
        .data        (data),
        .valid       (valid),
        .err         (err),
        .busy        (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used for exact timing checks
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: compare each valid word against the expected queue
    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid got=%h want=no_word", data);
            end else begin
                exp_w = exp_q.pop_front();
                if (data !== exp_w) begin
                    bad++;
                    $display("FAIL word_data got=%h want=%h", data, exp_w);
                end
            end
        end
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (valid && err) begin
            total++;
            bad++;
            $display("FAIL valid_err_overlap got=both_high want=exclusive");
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(OS);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic send_word(input logic [15:0] w);
        exp_q.push_back(w);
        send_byte(w[7:0], 1'b1);
        send_byte(w[15:8], 1'b1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        total++; if (data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h want=%h", data, 16'h0000); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        reset = 1'b0;
        tick(4);
    endtask

    task automatic test_word;
        int v0 = valid_cnt;
        int e0 = err_cnt;
        send_word(16'hA55A);
        tick(OS * 2);
        total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL word_valid_count got=%0d want=1", valid_cnt - v0); end
        total++; if (err_cnt != e0) begin bad++; $display("FAIL word_err_count got=%0d want=0", err_cnt - e0); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL word_pending got=%0d want=0", exp_q.size()); end
        total++; if (data !== 16'hA55A) begin bad++; $display("FAIL word_hold got=%h want=%h", data, 16'hA55A); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL word_busy got=%b want=0", busy); end
    endtask

    task automatic test_glitch;
        int v0 = valid_cnt;
        int e0 = err_cnt;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(200);
        total++; if (valid_cnt != v0) begin bad++; $display("FAIL glitch_valid got=%0d want=0", valid_cnt - v0); end
        total++; if (err_cnt != e0) begin bad++; $display("FAIL glitch_err got=%0d want=0", err_cnt - e0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b want=0", busy); end
        send_word(16'h1234);
        tick(OS * 2);
        total++; if (data !== 16'h1234) begin bad++; $display("FAIL glitch_next_word got=%h want=%h", data, 16'h1234); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL glitch_pending got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_framing;
        int v0 = valid_cnt;
        int e0 = err_cnt;
        send_byte(8'h77, 1'b0);
        rx = 1'b1;
        tick(OS * 3);
        total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL framing_err got=%0d want=1", err_cnt - e0); end
        total++; if (valid_cnt != v0) begin bad++; $display("FAIL framing_valid got=%0d want=0", valid_cnt - v0); end
        total++; if (data !== 16'h1234) begin bad++; $display("FAIL framing_data got=%h want=%h", data, 16'h1234); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL framing_busy got=%b want=0", busy); end
        send_word(16'hABCD);
        tick(OS * 2);
        total++; if (data !== 16'hABCD) begin bad++; $display("FAIL framing_next_word got=%h want=%h", data, 16'hABCD); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL framing_pending got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_timeout;
        int v0 = valid_cnt;
        int e0 = err_cnt;
        int c0 = cyc;
        send_byte(8'h12, 1'b1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL timeout_busy_hold got=%b want=1", busy); end
        rx = 1'b1;
        tick(OS * 25);
        total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL timeout_err got=%0d want=1", err_cnt - e0); end
        total++; if (err_cyc != c0 + STOP_LAT + TO_BITS * OS) begin bad++; $display("FAIL timeout_cycle got=%0d want=%0d", err_cyc - c0, STOP_LAT + TO_BITS * OS); end
        total++; if (valid_cnt != v0) begin bad++; $display("FAIL timeout_valid got=%0d want=0", valid_cnt - v0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy got=%b want=0", busy); end
        send_word(16'h5634);
        tick(OS * 2);
        total++; if (data !== 16'h5634) begin bad++; $display("FAIL timeout_next_word got=%h want=%h", data, 16'h5634); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL timeout_pending got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        int v0 = valid_cnt;
        int e0 = err_cnt;
        logic [7:0] b2 = 8'hC3;
        send_byte(8'h3C, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b2[i]);
        rx = b2[4];
        tick(OS / 2);
        reset = 1'b1;
        tick(1);
        total++; if (data !== 16'h0000) begin bad++; $display("FAIL midreset_data got=%h want=%h", data, 16'h0000); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b want=0", valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL midreset_err got=%b want=0", err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
        reset = 1'b0;
        rx = 1'b1;
        tick(OS * 12);
        total++; if (valid_cnt != v0) begin bad++; $display("FAIL midreset_valid_count got=%0d want=0", valid_cnt - v0); end
        total++; if (err_cnt != e0) begin bad++; $display("FAIL midreset_err_count got=%0d want=0", err_cnt - e0); end
        send_word(16'h00FF);
        tick(OS * 2);
        total++; if (data !== 16'h00FF) begin bad++; $display("FAIL midreset_next_word got=%h want=%h", data, 16'h00FF); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL midreset_pending got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        int v0 = valid_cnt;
        int e0 = err_cnt;
        send_word(16'h0001);
        send_word(16'h8000);
        send_word(16'hFFFF);
        tick(OS * 2);
        total++; if (valid_cnt - v0 != 3) begin bad++; $display("FAIL stream_valid_count got=%0d want=3", valid_cnt - v0); end
        total++; if (err_cnt != e0) begin bad++; $display("FAIL stream_err_count got=%0d want=0", err_cnt - e0); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stream_pending got=%0d want=0", exp_q.size()); end
        total++; if (data !== 16'hFFFF) begin bad++; $display("FAIL stream_last got=%h want=%h", data, 16'hFFFF); end
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_word();
        test_glitch();
        test_framing();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
